// File: rtl/dctq_pkg.sv
// Shared widths, default JPEG luminance reciprocal table and output saturation for dct_quantizer.
// DCTQ_TBL_LOAD_EN (see dctq_qtable) selects a loadable table instead of the constant ROM.
package dctq_pkg;

    localparam int DW     = 12;
    localparam int RW     = 16;
    localparam int RSHIFT = 15;
    localparam int QW     = 8;
    localparam int PW     = DW + RW + 1;
    localparam int QMAX   = 2 ** (QW - 1) - 1;

    typedef logic [5:0] idx_t;

    // round(32768 / Q) for the Annex K luminance table, row-major
    localparam logic [RW-1:0] QTBL_DEFAULT [64] = '{
        16'd2048, 16'd2979, 16'd3277, 16'd2048, 16'd1365, 16'd819,  16'd643,  16'd537,
        16'd2731, 16'd2731, 16'd2341, 16'd1725, 16'd1260, 16'd565,  16'd546,  16'd596,
        16'd2341, 16'd2521, 16'd2048, 16'd1365, 16'd819,  16'd575,  16'd475,  16'd585,
        16'd2341, 16'd1928, 16'd1489, 16'd1130, 16'd643,  16'd377,  16'd410,  16'd529,
        16'd1820, 16'd1489, 16'd886,  16'd585,  16'd482,  16'd301,  16'd318,  16'd426,
        16'd1365, 16'd936,  16'd596,  16'd512,  16'd405,  16'd315,  16'd290,  16'd356,
        16'd669,  16'd512,  16'd420,  16'd377,  16'd318,  16'd271,  16'd273,  16'd324,
        16'd455,  16'd356,  16'd345,  16'd334,  16'd293,  16'd328,  16'd318,  16'd331
    };

    // Clamp a rounded magnitude to QMAX and reapply the sign (symmetric range).
    function automatic logic [QW-1:0] sat_q(input logic neg, input logic [PW-1:0] mag);
        logic [QW-1:0] m;
        m = (mag > PW'(QMAX)) ? QW'(QMAX) : mag[QW-1:0];
        return neg ? -m : m;
    endfunction

endpackage

// File: rtl/dctq_qtable.sv
// Reciprocal table with combinational read: constant ROM by default, or a 64-entry
// register file reset to the defaults when DCTQ_TBL_LOAD_EN is defined.
module dctq_qtable
    import dctq_pkg::*;
(
`ifdef DCTQ_TBL_LOAD_EN
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tbl_we,
    input  logic [5:0]    tbl_addr,
    input  logic [RW-1:0] tbl_data,
`endif
    input  logic [5:0]    rd_addr,
    output logic [RW-1:0] rd_data
);

`ifdef DCTQ_TBL_LOAD_EN
    logic [RW-1:0] tbl [64];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 64; i++) begin
                tbl[i] <= QTBL_DEFAULT[i];
            end
        end else if (tbl_we) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end

    // Read sees the pre-write contents when address collides with a write this cycle
    assign rd_data = tbl[rd_addr];
`else
    assign rd_data = QTBL_DEFAULT[rd_addr];
`endif

endmodule

// File: rtl/dct_quantizer.sv
// Three-stage DCT coefficient quantizer: reciprocal multiply, round half away from zero,
// symmetric saturation. DCTQ_TBL_LOAD_EN adds the tbl_* write port for the reciprocal table.
module dct_quantizer
    import dctq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din_valid,
    input  logic          blk_start,
    input  logic [DW-1:0] dct_in,
    output logic          q_valid,
    output logic [QW-1:0] q_out,
    output logic [5:0]    q_idx,
    output logic          q_last
`ifdef DCTQ_TBL_LOAD_EN
    ,
    input  logic          tbl_we,
    input  logic [5:0]    tbl_addr,
    input  logic [RW-1:0] tbl_data
`endif
);

    localparam logic [PW-1:0] RND_HALF = PW'(1) << (RSHIFT - 1);

    idx_t          cnt;
    idx_t          idx_in;
    logic          s1_valid;
    logic [DW-1:0] s1_din;
    idx_t          s1_idx;
    logic [RW-1:0] recip;
    logic          s2_valid;
    idx_t          s2_idx;
    logic [PW-1:0] s2_p;

    logic signed [PW-1:0] din_ext;
    logic signed [PW-1:0] rcp_ext;
    logic signed [PW-1:0] prod;
    logic                 neg;
    logic [PW-1:0]        mag;
    logic [PW-1:0]        rnd;
    logic [QW-1:0]        q_sat;

    dctq_qtable u_qtable (
`ifdef DCTQ_TBL_LOAD_EN
        .clk      (clk),
        .rst_n    (rst_n),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
`endif
        .rd_addr  (s1_idx),
        .rd_data  (recip)
    );

    always_comb begin
        idx_in = blk_start ? '0 : cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_din   <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) begin
                cnt    <= idx_in + 6'd1;
                s1_din <= dct_in;
                s1_idx <= idx_in;
            end
        end
    end

    // Both operands extended to full product width so the 29-bit product is exact
    always_comb begin
        din_ext = {{(PW-DW){s1_din[DW-1]}}, s1_din};
        rcp_ext = {{(PW-RW){1'b0}}, recip};
        prod    = din_ext * rcp_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            s2_p     <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_idx <= s1_idx;
                s2_p   <= prod;
            end
        end
    end

    always_comb begin
        neg   = s2_p[PW-1];
        mag   = neg ? -s2_p : s2_p;
        rnd   = (mag + RND_HALF) >> RSHIFT;
        q_sat = sat_q(neg, rnd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_out   <= '0;
            q_idx   <= '0;
            q_last  <= 1'b0;
        end else begin
            q_valid <= s2_valid;
            q_last  <= s2_valid && (s2_idx == 6'd63);
            if (s2_valid) begin
                q_out <= q_sat;
                q_idx <= s2_idx;
            end
        end
    end

endmodule

// File: tb/tb_dct_quantizer.sv
// Directed self-checking bench for dct_quantizer; the table-load steps build only
// when DCTQ_TBL_LOAD_EN is defined.
module tb_dct_quantizer;

    logic        clk;
    logic        rst_n;
    logic        din_valid;
    logic        blk_start;
    logic [11:0] dct_in;
    logic        q_valid;
    logic [7:0]  q_out;
    logic [5:0]  q_idx;
    logic        q_last;
`ifdef DCTQ_TBL_LOAD_EN
    logic        tbl_we;
    logic [5:0]  tbl_addr;
    logic [15:0] tbl_data;
`endif

    int tests = 0;
    int fails = 0;

    dct_quantizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_valid (din_valid),
        .blk_start (blk_start),
        .dct_in    (dct_in),
        .q_valid   (q_valid),
        .q_out     (q_out),
        .q_idx     (q_idx),
`ifdef DCTQ_TBL_LOAD_EN
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
`endif
        .q_last    (q_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ev, input logic signed [7:0] eo,
                       input logic [5:0] ei, input logic el);
        tests += 4;
        assert (q_valid === ev) else begin
            fails++;
            $error("FAIL %s q_valid: got %0b expected %0b", tag, q_valid, ev);
        end
        assert (q_out === eo) else begin
            fails++;
            $error("FAIL %s q_out: got %0d expected %0d", tag, $signed(q_out), eo);
        end
        assert (q_idx === ei) else begin
            fails++;
            $error("FAIL %s q_idx: got %0d expected %0d", tag, q_idx, ei);
        end
        assert (q_last === el) else begin
            fails++;
            $error("FAIL %s q_last: got %0b expected %0b", tag, q_last, el);
        end
    endtask

    // One block-start sample at idx 0 (recip 2048), result checked after three edges
    task automatic one(input string tag, input logic signed [11:0] d, input logic signed [7:0] e);
        din_valid = 1'b1;
        blk_start = 1'b1;
        dct_in    = d;
        tick();
        din_valid = 1'b0;
        blk_start = 1'b0;
        tick();
        tick();
        chk(tag, 1'b1, e, 6'd0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        din_valid = 1'b0;
        blk_start = 1'b0;
        dct_in    = '0;
`ifdef DCTQ_TBL_LOAD_EN
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_data  = '0;
`endif
        tick();
        tick();
        chk("reset", 1'b0, 8'sd0, 6'd0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Latency: 100 * 2048 / 32768 = 6.25 -> 6
        din_valid = 1'b1;
        blk_start = 1'b1;
        dct_in    = 12'sd100;
        tick();
        din_valid = 1'b0;
        blk_start = 1'b0;
        chk("lat1", 1'b0, 8'sd0, 6'd0, 1'b0);
        tick();
        chk("lat2", 1'b0, 8'sd0, 6'd0, 1'b0);
        tick();
        chk("pos100", 1'b1, 8'sd6, 6'd0, 1'b0);
        tick();
        chk("hold", 1'b0, 8'sd6, 6'd0, 1'b0);

        one("neg100", -12'sd100, -8'sd6);
        one("zero", 12'sd0, 8'sd0);
        one("sat_pos", 12'sd2047, 8'sd127);
        one("sat_neg", -12'sd2048, -8'sd127);
        // 20 * 2048 = 1.25 -> 1 ; -24 -> -1.5 rounds away to -2
        one("rnd_pos", 12'sd20, 8'sd1);
        one("rnd_half", -12'sd24, -8'sd2);

        // 66 back-to-back samples; idx 1 uses recip 2979: 100 -> 9.09 -> 9
        for (int i = 0; i < 68; i++) begin
            din_valid = (i < 66);
            blk_start = (i == 0);
            dct_in    = (i == 1) ? 12'sd100 : 12'sd0;
            tick();
            if (i >= 2) begin
                chk($sformatf("stream%0d", i - 2), 1'b1, (i == 3) ? 8'sd9 : 8'sd0,
                    6'((i - 2) % 64), (i - 2) == 63);
            end
        end

        // Two bubbles between samples at idx 2 and idx 3
        din_valid = 1'b1;
        blk_start = 1'b0;
        dct_in    = 12'sd0;
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        chk("bub_a", 1'b1, 8'sd0, 6'd2, 1'b0);
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("bub_gap1", 1'b0, 8'sd0, 6'd2, 1'b0);
        tick();
        chk("bub_gap2", 1'b0, 8'sd0, 6'd2, 1'b0);
        tick();
        chk("bub_b", 1'b1, 8'sd0, 6'd3, 1'b0);
        tick();

        // Reset with samples in flight
        din_valid = 1'b1;
        dct_in    = 12'sd100;
        tick();
        tick();
        tick();
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_async", 1'b0, 8'sd0, 6'd0, 1'b0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("rst_flush1", 1'b0, 8'sd0, 6'd0, 1'b0);
        tick();
        chk("rst_flush2", 1'b0, 8'sd0, 6'd0, 1'b0);
        tick();
        chk("rst_flush3", 1'b0, 8'sd0, 6'd0, 1'b0);
        din_valid = 1'b1;
        blk_start = 1'b0;
        dct_in    = 12'sd100;
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        chk("rst_idx0", 1'b1, 8'sd6, 6'd0, 1'b0);

`ifdef DCTQ_TBL_LOAD_EN
        // Q=1 at idx 5: -37 passes through unchanged
        tbl_we   = 1'b1;
        tbl_addr = 6'd5;
        tbl_data = 16'd32768;
        tick();
        tbl_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din_valid = 1'b1;
            blk_start = (i == 0);
            dct_in    = (i == 5) ? -12'sd37 : 12'sd0;
            tick();
        end
        din_valid = 1'b0;
        blk_start = 1'b0;
        tick();
        tick();
        chk("tbl_q1", 1'b1, -8'sd37, 6'd5, 1'b0);

        // Write addr 5 back to 2048 in the same cycle its entry is read: old value used
        for (int i = 0; i < 6; i++) begin
            din_valid = 1'b1;
            blk_start = (i == 0);
            dct_in    = (i == 5) ? -12'sd37 : 12'sd0;
            tick();
        end
        din_valid = 1'b0;
        blk_start = 1'b0;
        tbl_we    = 1'b1;
        tbl_addr  = 6'd5;
        tbl_data  = 16'd2048;
        tick();
        tbl_we = 1'b0;
        tick();
        chk("tbl_same", 1'b1, -8'sd37, 6'd5, 1'b0);

        // New value now in effect: -37 * 2048 / 32768 = -2.31 -> -2
        for (int i = 0; i < 6; i++) begin
            din_valid = 1'b1;
            blk_start = (i == 0);
            dct_in    = (i == 5) ? -12'sd37 : 12'sd0;
            tick();
        end
        din_valid = 1'b0;
        blk_start = 1'b0;
        tick();
        tick();
        chk("tbl_new", 1'b1, -8'sd2, 6'd5, 1'b0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
